// File: rtl/fp_addsub_resbuf_if.sv
// Signal bundle between the add/sub result buffer and its environment.
// The dispatcher credit, the add/sub result beat and the interconnect handshake are all grouped here.
interface fp_addsub_resbuf_if #(
    parameter int DEPTH      = 4,
    parameter int FP_WIDTH   = 32,
    parameter int TAG_WIDTH  = 5,
    parameter int STAT_WIDTH = 8
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                  issue_i;
    logic                  issue_gnt_o;
    logic                  res_valid_i;
    logic [FP_WIDTH-1:0]   res_i;
    logic [TAG_WIDTH-1:0]  tag_i;
    logic [STAT_WIDTH-1:0] status_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [FP_WIDTH-1:0]   out_res_o;
    logic [TAG_WIDTH-1:0]  out_tag_o;
    logic [STAT_WIDTH-1:0] out_status_o;
    logic [CNT_W-1:0]      inflight_o;
    logic                  err_o;

    // Environment side: dispatcher, add/sub unit and interconnect.
    modport master (
        output issue_i, res_valid_i, res_i, tag_i, status_i, out_ready_i,
        input  issue_gnt_o, out_valid_o, out_res_o, out_tag_o, out_status_o, inflight_o, err_o
    );

    // Buffer side.
    modport slave (
        input  issue_i, res_valid_i, res_i, tag_i, status_i, out_ready_i,
        output issue_gnt_o, out_valid_o, out_res_o, out_tag_o, out_status_o, inflight_o, err_o
    );
endinterface

// File: rtl/fp_addsub_resbuf.sv
// Credit-managed result FIFO behind the stall-free FP add/sub unit.
// Optional macro FP_RESBUF_BYPASS_EN: zero-latency pass-through when empty and the interconnect is ready.
module fp_addsub_resbuf #(
    parameter int DEPTH      = 4,
    parameter int FP_WIDTH   = 32,
    parameter int TAG_WIDTH  = 5,
    parameter int STAT_WIDTH = 8,
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    fp_addsub_resbuf_if.slave  rb_if
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ENT_W = FP_WIDTH + TAG_WIDTH + STAT_WIDTH;

    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             err_q, err_d;

    logic [CNT_W:0]   credit_sum;
    logic             gnt, full, empty;
    logic             byp, pop, push, issue_acc, ret;
    logic [ENT_W-1:0] wr_data, head;
    logic [ENT_W-1:0] ent_rd [DEPTH];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Grant is a pure function of registered state, so a pop never raises it in the same cycle.
    assign credit_sum = {1'b0, inflight_q} + {1'b0, count_q};
    assign gnt        = credit_sum < (CNT_W + 1)'(DEPTH);
    assign full       = count_q == CNT_W'(DEPTH);
    assign empty      = count_q == '0;
    assign wr_data    = {rb_if.res_i, rb_if.tag_i, rb_if.status_i};
    assign head       = ent_rd[rd_ptr_q];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
        logic [ENT_W-1:0] ent_q;
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                ent_q <= '0;
            end else if (push && (wr_ptr_q == PTR_W'(gi))) begin
                ent_q <= wr_data;
            end
        end
        assign ent_rd[gi] = ent_q;
    end

    always_comb begin
        byp = 1'b0;
`ifdef FP_RESBUF_BYPASS_EN
        byp = empty & rb_if.res_valid_i & rb_if.out_ready_i;
`endif
        pop       = !empty & rb_if.out_ready_i;
        push      = rb_if.res_valid_i & !byp & (!full | pop);
        issue_acc = rb_if.issue_i & gnt;
        ret       = rb_if.res_valid_i & (inflight_q != '0);

        inflight_d = inflight_q;
        if (issue_acc && !ret) begin
            inflight_d = inflight_q + 1'b1;
        end else if (!issue_acc && ret) begin
            inflight_d = inflight_q - 1'b1;
        end

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end

        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;

        // Over-issue, overflow drop and underflow return are all sticky until reset.
        err_d = err_q
              | (rb_if.issue_i & !gnt)
              | (rb_if.res_valid_i & full & !pop)
              | (rb_if.res_valid_i & (inflight_q == '0));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q    <= '0;
            inflight_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            count_q    <= count_d;
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            err_q      <= err_d;
        end
    end

    assign rb_if.issue_gnt_o = gnt;
    assign rb_if.inflight_o  = inflight_q;
    assign rb_if.err_o       = err_q;
    assign rb_if.out_valid_o = !empty | byp;

`ifdef FP_RESBUF_BYPASS_EN
    assign {rb_if.out_res_o, rb_if.out_tag_o, rb_if.out_status_o} = byp ? wr_data : head;
`else
    assign {rb_if.out_res_o, rb_if.out_tag_o, rb_if.out_status_o} = head;
`endif
endmodule

// File: tb/tb_fp_addsub_resbuf.sv
// Directed scoreboard bench for fp_addsub_resbuf: a DEPTH=4 instance for credit/ordering/violation/reset
// and a DEPTH=3 instance for pointer wrap under alternating backpressure.
module tb_fp_addsub_resbuf;
    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  tag;
        logic [7:0]  stat;
    } beat_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    int    checks = 0;
    int    failures = 0;
    beat_t sb_a[$];
    beat_t sb_b[$];

    always #5 clk = ~clk;

    fp_addsub_resbuf_if #(.DEPTH(4)) bus_a ();
    fp_addsub_resbuf_if #(.DEPTH(3)) bus_b ();

    fp_addsub_resbuf #(.DEPTH(4)) dut_a (.clk_i(clk), .rst_i(rst), .rb_if(bus_a));
    fp_addsub_resbuf #(.DEPTH(3)) dut_b (.clk_i(clk), .rst_i(rst), .rb_if(bus_b));

    function automatic logic [7:0] stat_of(input logic [4:0] t);
        return {3'b101, t} ^ 8'h3C;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; checks follow 2 units later.
    task automatic cyc_a(input logic iss, input logic rv, input logic [31:0] res,
                         input logic [4:0] tag, input logic rdy, input logic keep);
        @(posedge clk);
        #1;
        bus_a.issue_i     = iss;
        bus_a.res_valid_i = rv;
        bus_a.res_i       = res;
        bus_a.tag_i       = tag;
        bus_a.status_i    = stat_of(tag);
        bus_a.out_ready_i = rdy;
        if (rv && keep) sb_a.push_back(beat_t'{res, tag, stat_of(tag)});
        #2;
    endtask

    task automatic cyc_b(input logic iss, input logic rv, input logic [31:0] res,
                         input logic [4:0] tag, input logic rdy, input logic keep);
        @(posedge clk);
        #1;
        bus_b.issue_i     = iss;
        bus_b.res_valid_i = rv;
        bus_b.res_i       = res;
        bus_b.tag_i       = tag;
        bus_b.status_i    = stat_of(tag);
        bus_b.out_ready_i = rdy;
        if (rv && keep) sb_b.push_back(beat_t'{res, tag, stat_of(tag)});
        #2;
    endtask

    always @(negedge clk) begin
        if (!rst && bus_a.out_valid_o && bus_a.out_ready_i) begin
            chk("a_sb_nonempty", 64'(sb_a.size() != 0), 64'd1);
            if (sb_a.size() != 0) begin
                beat_t e;
                e = sb_a.pop_front();
                chk("a_out_tag", 64'(bus_a.out_tag_o), 64'(e.tag));
                chk("a_out_res", 64'(bus_a.out_res_o), 64'(e.res));
                chk("a_out_status", 64'(bus_a.out_status_o), 64'(e.stat));
            end
        end
        if (!rst && bus_b.out_valid_o && bus_b.out_ready_i) begin
            chk("b_sb_nonempty", 64'(sb_b.size() != 0), 64'd1);
            if (sb_b.size() != 0) begin
                beat_t e;
                e = sb_b.pop_front();
                chk("b_out_tag", 64'(bus_b.out_tag_o), 64'(e.tag));
                chk("b_out_res", 64'(bus_b.out_res_o), 64'(e.res));
            end
        end
    end

    initial begin
        int   m_cnt, m_inf, issued, returned, c;
        logic iss, rv, rdy, byp, pop, push, gnt_m;

        bus_a.issue_i = 0; bus_a.res_valid_i = 0; bus_a.res_i = '0; bus_a.tag_i = '0;
        bus_a.status_i = '0; bus_a.out_ready_i = 0;
        bus_b.issue_i = 0; bus_b.res_valid_i = 0; bus_b.res_i = '0; bus_b.tag_i = '0;
        bus_b.status_i = '0; bus_b.out_ready_i = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #2;

        // Reset state
        chk("rst_valid", 64'(bus_a.out_valid_o), 64'd0);
        chk("rst_gnt", 64'(bus_a.issue_gnt_o), 64'd1);
        chk("rst_inflight", 64'(bus_a.inflight_o), 64'd0);
        chk("rst_err", 64'(bus_a.err_o), 64'd0);
        chk("rst_res", 64'(bus_a.out_res_o), 64'd0);
        chk("rst_tag", 64'(bus_a.out_tag_o), 64'd0);
        chk("rst_status", 64'(bus_a.out_status_o), 64'd0);
        chk("rst_b_valid", 64'(bus_b.out_valid_o), 64'd0);
        chk("rst_b_gnt", 64'(bus_b.issue_gnt_o), 64'd1);

        // Exhaust credits, fill the FIFO under backpressure, then drain
        cyc_a(1, 0, 0, 0, 0, 0);
        cyc_a(1, 0, 0, 0, 0, 0);
        chk("fill_inflight1", 64'(bus_a.inflight_o), 64'd1);
        chk("fill_gnt1", 64'(bus_a.issue_gnt_o), 64'd1);
        cyc_a(1, 0, 0, 0, 0, 0);
        cyc_a(1, 0, 0, 0, 0, 0);
        cyc_a(0, 1, 32'h3F800000, 5'd1, 0, 1);
        chk("fill_gnt_drop", 64'(bus_a.issue_gnt_o), 64'd0);
        chk("fill_inflight4", 64'(bus_a.inflight_o), 64'd4);
        cyc_a(0, 1, 32'h3F800000, 5'd2, 0, 1);
        cyc_a(0, 1, 32'h3F800000, 5'd3, 0, 1);
        cyc_a(0, 1, 32'h3F800000, 5'd4, 0, 1);
        cyc_a(0, 0, 0, 0, 0, 0);
        chk("full_valid", 64'(bus_a.out_valid_o), 64'd1);
        chk("full_head_tag", 64'(bus_a.out_tag_o), 64'd1);
        chk("full_inflight0", 64'(bus_a.inflight_o), 64'd0);
        chk("full_gnt", 64'(bus_a.issue_gnt_o), 64'd0);
        chk("full_err", 64'(bus_a.err_o), 64'd0);
        cyc_a(0, 0, 0, 0, 0, 0);
        chk("hold_head_tag", 64'(bus_a.out_tag_o), 64'd1);
        chk("hold_head_res", 64'(bus_a.out_res_o), 64'h3F800000);
        cyc_a(0, 0, 0, 0, 1, 0);
        chk("pop_gnt_same_cycle", 64'(bus_a.issue_gnt_o), 64'd0);
        cyc_a(0, 0, 0, 0, 1, 0);
        chk("pop_gnt_next_cycle", 64'(bus_a.issue_gnt_o), 64'd1);
        chk("pop_head_tag2", 64'(bus_a.out_tag_o), 64'd2);
        cyc_a(0, 0, 0, 0, 1, 0);
        cyc_a(0, 0, 0, 0, 1, 0);
        cyc_a(0, 0, 0, 0, 0, 0);
        chk("drain_valid", 64'(bus_a.out_valid_o), 64'd0);
        chk("drain_sb_empty", 64'(sb_a.size()), 64'd0);

        // Streaming: issue and return every cycle with the interconnect always ready
        cyc_a(1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 20; i++) begin
            cyc_a(i < 19, 1, 32'h40490000 ^ (32'(i) << 4), 5'(i), 1, 1);
            chk("stream_inflight", 64'(bus_a.inflight_o), 64'd1);
`ifdef FP_RESBUF_BYPASS_EN
            chk("stream_valid", 64'(bus_a.out_valid_o), 64'd1);
            chk("stream_tag_lat0", 64'(bus_a.out_tag_o), 64'(i));
`else
            chk("stream_valid", 64'(bus_a.out_valid_o), 64'(i > 0));
            if (i > 0) chk("stream_tag_lat1", 64'(bus_a.out_tag_o), 64'(i - 1));
`endif
        end
        cyc_a(0, 0, 0, 0, 1, 0);
        cyc_a(0, 0, 0, 0, 0, 0);
        chk("stream_inflight_end", 64'(bus_a.inflight_o), 64'd0);
        chk("stream_err", 64'(bus_a.err_o), 64'd0);
        chk("stream_sb_empty", 64'(sb_a.size()), 64'd0);
        chk("stream_valid_end", 64'(bus_a.out_valid_o), 64'd0);

        // Over-issue while grant is low: flagged, not counted
        repeat (4) cyc_a(1, 0, 0, 0, 0, 0);
        cyc_a(1, 0, 0, 0, 0, 0);
        cyc_a(0, 0, 0, 0, 0, 0);
        chk("overissue_err", 64'(bus_a.err_o), 64'd1);
        chk("overissue_inflight", 64'(bus_a.inflight_o), 64'd4);
        for (int j = 0; j < 4; j++) cyc_a(0, 1, 32'hBF800000, 5'(10 + j), 1, 1);
        cyc_a(0, 0, 0, 0, 1, 0);
        cyc_a(0, 0, 0, 0, 0, 0);
        chk("overissue_sb_empty", 64'(sb_a.size()), 64'd0);
        chk("overissue_inflight0", 64'(bus_a.inflight_o), 64'd0);

        // Mid-operation reset with 2 stored and 1 in flight, then a stale return
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; #2;
        chk("rst2_err_clear", 64'(bus_a.err_o), 64'd0);
        repeat (3) cyc_a(1, 0, 0, 0, 0, 0);
        cyc_a(0, 1, 32'h41200000, 5'd17, 0, 1);
        cyc_a(0, 1, 32'h41300000, 5'd18, 0, 1);
        cyc_a(0, 0, 0, 0, 0, 0);
        chk("pre_rst_inflight", 64'(bus_a.inflight_o), 64'd1);
        chk("pre_rst_valid", 64'(bus_a.out_valid_o), 64'd1);
        @(posedge clk); #1 rst = 1'b1; sb_a.delete();
        @(posedge clk); #1 rst = 1'b0; #2;
        chk("post_rst_valid", 64'(bus_a.out_valid_o), 64'd0);
        chk("post_rst_inflight", 64'(bus_a.inflight_o), 64'd0);
        chk("post_rst_gnt", 64'(bus_a.issue_gnt_o), 64'd1);
        chk("post_rst_res", 64'(bus_a.out_res_o), 64'd0);
        cyc_a(0, 1, 32'h41400000, 5'd21, 0, 1);
        cyc_a(0, 0, 0, 0, 1, 0);
        chk("underflow_err", 64'(bus_a.err_o), 64'd1);
        chk("underflow_valid", 64'(bus_a.out_valid_o), 64'd1);
        chk("underflow_tag", 64'(bus_a.out_tag_o), 64'd21);
        chk("underflow_inflight", 64'(bus_a.inflight_o), 64'd0);
        cyc_a(0, 0, 0, 0, 0, 0);
        chk("underflow_sb_empty", 64'(sb_a.size()), 64'd0);

        // DEPTH=3: credit-driven traffic with alternating ready, 7 beats across the pointer wrap
        m_cnt = 0; m_inf = 0; issued = 0; returned = 0; c = 0;
        while (c < 80 && !(returned == 7 && m_cnt == 0)) begin
            gnt_m = (m_inf + m_cnt) < 3;
            iss   = gnt_m && (issued < 7);
            rv    = (m_inf > 0) && (c % 3 != 2);
            rdy   = (c % 2 == 1);
`ifdef FP_RESBUF_BYPASS_EN
            byp   = (m_cnt == 0) && rv && rdy;
`else
            byp   = 1'b0;
`endif
            pop   = (m_cnt != 0) && rdy;
            push  = rv && !byp && ((m_cnt < 3) || pop);
            cyc_b(iss, rv, 32'hC0000000 | 32'(returned), 5'(returned + 1), rdy, push || byp);
            chk("wrap_gnt", 64'(bus_b.issue_gnt_o), 64'(gnt_m));
            chk("wrap_inflight", 64'(bus_b.inflight_o), 64'(m_inf));
            chk("wrap_valid", 64'(bus_b.out_valid_o), 64'((m_cnt != 0) || byp));
            m_cnt    = m_cnt + int'(push) - int'(pop);
            m_inf    = m_inf + int'(iss) - int'(rv);
            issued   = issued + int'(iss);
            returned = returned + int'(rv);
            c++;
        end
        cyc_b(0, 0, 0, 0, 0, 0);
        chk("wrap_all_returned", 64'(returned), 64'd7);
        chk("wrap_err", 64'(bus_b.err_o), 64'd0);
        chk("wrap_sb_empty", 64'(sb_b.size()), 64'd0);
        chk("wrap_valid_end", 64'(bus_b.out_valid_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fp_addsub_resbuf.md
Name: fp_addsub_resbuf

Overview:
- Result buffer directly downstream of the FP add/sub wrapper. That unit has no stall input: it reports Ready permanently high and emits a result whenever its pipeline delivers one.
- This block captures every result/tag/status beat into a small FIFO and presents it to the shared result interconnect with valid/ready backpressure.
- It issues credits to the upstream dispatcher, so no more operations are in flight than the buffer can absorb. This makes drop-free operation under backpressure guaranteed.

Parameters:
- DEPTH, 4, FIFO entries and total credit count; >=1, non-power-of-two allowed
- FP_WIDTH, 32, result width
- TAG_WIDTH, 5, tag width
- STAT_WIDTH, 8, status flag width
- CNT_W, $clog2(DEPTH+1), width of occupancy/in-flight counters (derived, not overridden)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset (one clock, clk_i, for the whole block)
- issue_i  in  1  dispatcher launches one op into the add/sub unit this cycle (mirrors unit enable)
- issue_gnt_o  out  1  credit available; dispatcher may assert issue_i only when high
- res_valid_i  in  1  add/sub unit Valid
- res_i  in  FP_WIDTH  add/sub unit result
- tag_i  in  TAG_WIDTH  add/sub unit tag
- status_i  in  STAT_WIDTH  add/sub unit status flags
- out_valid_o  out  1  head entry valid toward interconnect
- out_ready_i  in  1  interconnect accepts head entry
- out_res_o  out  FP_WIDTH  head result
- out_tag_o  out  TAG_WIDTH  head tag
- out_status_o  out  STAT_WIDTH  head status
- inflight_o  out  CNT_W  ops issued but not yet returned
- err_o  out  1  sticky protocol-violation flag

Behaviour:
- Reset (synchronous, rst_i high at clk_i edge):
  - count, inflight, rd/wr pointers = 0; err_o = 0
  - all storage entries = 0, so out_res_o/out_tag_o/out_status_o = 0
  - out_valid_o = 0; issue_gnt_o = 1
  - rst_i mid-operation discards all stored entries and in-flight accounting; results still draining from the unit afterwards are treated as per the underflow rule.
- Credit:
  - issue_gnt_o = (inflight + count) < DEPTH, computed from registered values only.
  - A pop in the same cycle does not raise the grant; the credit returns next cycle.
- inflight update:
  - +1 on accepted issue (issue_i & issue_gnt_o)
  - -1 on res_valid_i
  - both in the same cycle: unchanged
  - never decrements below 0
- FIFO:
  - push on res_valid_i when count<DEPTH; pop on out_valid_o & out_ready_i
  - simultaneous push and pop: count unchanged, both pointers advance
  - pointers wrap from DEPTH-1 to 0
- Output:
  - first-word-fall-through from registered storage; out_valid_o = (count != 0)
  - latency res_valid_i -> out_valid_o is 1 cycle
  - head outputs are stable while out_valid_o & !out_ready_i
  - ordering is strict FIFO; tags are passed through untouched
- Violations (each sets err_o until reset):
  - issue_i while issue_gnt_o=0: the op is not counted
  - res_valid_i while count==DEPTH and no pop: the beat is dropped
  - res_valid_i while inflight==0: the beat is still pushed if space
- The block performs no arithmetic on data; counters saturate within 0..DEPTH.

Optional Feature:
- Macro: FP_RESBUF_BYPASS_EN.
- When defined: if count==0 and res_valid_i & out_ready_i, the beat is driven combinationally onto the out_* ports in the same cycle (out_valid_o=1) and is not written to the FIFO. Latency is 0 in this case; otherwise behaviour is unchanged.
  - If count==0, res_valid_i=1 and out_ready_i=0: the beat is pushed normally.
- When undefined: no combinational path from res_* to out_*; latency is always 1.

Test Plan:
- Reset then idle -> out_valid_o=0, issue_gnt_o=1, inflight_o=0, err_o=0, out_res_o=0.
- DEPTH=4, out_ready_i=0, issue 4 ops on consecutive cycles -> issue_gnt_o drops to 0 the cycle after the 4th issue. Return results 0x3F800000/tag 1..4 -> count=4, inflight_o=0, issue_gnt_o stays 0. Raise out_ready_i -> tags 1,2,3,4 emitted in order on consecutive cycles; grant reasserts 1 cycle after the first pop.
- Simultaneous issue_i and res_valid_i every cycle with out_ready_i=1 for 20 cycles -> inflight_o constant, no err_o, all 20 tags out in order with 1-cycle latency (0 with FP_RESBUF_BYPASS_EN).
- Wrap-around, DEPTH=3: push/pop 7 entries with alternating out_ready_i -> correct order across the pointer wrap, count never exceeds 3.
- Violations: issue_i while grant=0 -> err_o=1, inflight unchanged. res_valid_i with inflight=0 -> err_o=1, entry still delivered.
- Assert rst_i with 2 entries stored and 1 in flight -> next cycle count=0, out_valid_o=0, inflight_o=0, issue_gnt_o=1.
